// File: rtl/can_id_fifo_if.sv
// Handshake bundle between the CAN acceptance filter, the ID FIFO and the host consumer.
// With CAN_FIFO_TIMESTAMP_EN defined the head timestamp rd_ts is carried as well.
interface can_id_fifo_if;
  logic [10:0] id_in;
  logic        id_valid_in;
  logic [10:0] rd_id;
  logic        rd_valid;
  logic        rd_ready;
`ifdef CAN_FIFO_TIMESTAMP_EN
  logic [31:0] rd_ts;

  modport slave (
    input  id_in, id_valid_in, rd_ready,
    output rd_id, rd_valid, rd_ts
  );
  modport master (
    output id_in, id_valid_in, rd_ready,
    input  rd_id, rd_valid, rd_ts
  );
`else
  modport slave (
    input  id_in, id_valid_in, rd_ready,
    output rd_id, rd_valid
  );
  modport master (
    output id_in, id_valid_in, rd_ready,
    input  rd_id, rd_valid
  );
`endif
endinterface

// File: rtl/can_id_fifo.sv
// FWFT queue of accepted CAN IDs with sticky overflow flag and saturating drop counter.
// Optional per-entry 32-bit timestamp enabled by defining CAN_FIFO_TIMESTAMP_EN.
module can_id_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  can_id_fifo_if.slave               bus,
  input  logic                       flush,
  input  logic                       clear_ovf,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef CAN_FIFO_TIMESTAMP_EN
  localparam int DW = 43;
`else
  localparam int DW = 11;
`endif

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("can_id_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
      $error("can_id_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end
  endgenerate

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [DW-1:0]    wr_data;
  logic [DW-1:0]    head;
  logic             rd_valid_i;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             dc_sat;

`ifdef CAN_FIFO_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 32'd1;
  end

  assign wr_data    = {ts_cnt, bus.id_in};
  assign bus.rd_ts  = rd_valid_i ? head[42:11] : 32'd0;
`else
  assign wr_data    = bus.id_in;
`endif

  assign rd_valid_i = (level_q != '0);
  assign full       = (level_q == LW'(DEPTH));
  assign head       = mem[rd_ptr];
  assign pop        = rd_valid_i && bus.rd_ready;
  assign push_ok    = bus.id_valid_in && (!full || pop);
  // A push lost to flush is discarded silently, not reported as a drop.
  assign drop       = bus.id_valid_in && full && !pop && !flush;
  assign dc_sat     = &drop_count;

  assign bus.rd_valid = rd_valid_i;
  assign bus.rd_id    = rd_valid_i ? head[10:0] : 11'd0;
  assign level        = level_q;
  assign almost_full  = (level_q >= LW'(AFULL_THRESH));

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop in the same cycle as clear_ovf restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf)   drop_count <= CNT_W'(1);
      else if (!dc_sat) drop_count <= drop_count + 1'b1;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_can_id_fifo.sv
// Directed, table-driven bench for can_id_fifo (DEPTH=16, AFULL_THRESH=12, CNT_W=16).
module tb_can_id_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [4:0]  level;
  logic        almost_full;
  logic        overflow;
  logic [15:0] drop_count;
  int          checks = 0;
  int          failures = 0;

  can_id_fifo_if bus ();

  can_id_fifo #(.DEPTH(16), .AFULL_THRESH(12), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .clear_ovf   (clear_ovf),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_v;
    logic        vld;
    logic [10:0] id;
    logic        rdy;
    logic        fl;
    logic        clr;
    int          lvl;
    logic        rv;
    logic [10:0] rid;
    logic        ovf;
    int          dc;
    logic        af;
  } vec_t;

  function automatic vec_t mk(input logic rst_v, input logic vld, input logic [10:0] id,
                              input logic rdy, input logic fl, input logic clr,
                              input int lvl, input logic rv, input logic [10:0] rid,
                              input logic ovf, input int dc, input logic af);
    vec_t v;
    v.rst_v = rst_v; v.vld = vld; v.id = id; v.rdy = rdy; v.fl = fl; v.clr = clr;
    v.lvl = lvl; v.rv = rv; v.rid = rid; v.ovf = ovf; v.dc = dc; v.af = af;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", nm, tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check post-edge outputs.
  task automatic apply(input vec_t v, input int tag);
    rst             = v.rst_v;
    bus.id_valid_in = v.vld;
    bus.id_in       = v.id;
    bus.rd_ready    = v.rdy;
    flush           = v.fl;
    clear_ovf       = v.clr;
    @(posedge clk);
    #1;
    chk("level", tag, 32'(level), 32'(v.lvl));
    chk("rd_valid", tag, 32'(bus.rd_valid), 32'(v.rv));
    chk("rd_id", tag, 32'(bus.rd_id), 32'(v.rid));
    chk("overflow", tag, 32'(overflow), 32'(v.ovf));
    chk("drop_count", tag, 32'(drop_count), 32'(v.dc));
    chk("almost_full", tag, 32'(almost_full), 32'(v.af));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t basic [8];

  initial begin
    basic[0] = mk(0, 1, 11'h100, 0, 0, 0, 1, 1, 11'h100, 0, 0, 0);
    basic[1] = mk(0, 1, 11'h250, 0, 0, 0, 2, 1, 11'h100, 0, 0, 0);
    basic[2] = mk(0, 1, 11'h7FF, 0, 0, 0, 3, 1, 11'h100, 0, 0, 0);
    basic[3] = mk(0, 0, 11'h000, 1, 0, 0, 2, 1, 11'h250, 0, 0, 0);
    basic[4] = mk(0, 0, 11'h000, 1, 0, 0, 1, 1, 11'h7FF, 0, 0, 0);
    basic[5] = mk(0, 0, 11'h000, 1, 0, 0, 0, 0, 11'h000, 0, 0, 0);
    basic[6] = mk(0, 0, 11'h000, 1, 0, 0, 0, 0, 11'h000, 0, 0, 0);
    basic[7] = mk(0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0);

    bus.id_in = '0; bus.id_valid_in = 1'b0; bus.rd_ready = 1'b0;

    // Reset, with a write strobe that must be ignored, then first cycle after.
    apply(mk(1, 1, 11'h123, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    apply(mk(1, 0, 11'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    apply(mk(0, 0, 11'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2);

    for (int i = 0; i < 8; i++) apply(basic[i], 10 + i);

    // Fill to full; almost_full from level 12.
    for (int i = 0; i < 16; i++)
      apply(mk(0, 1, 11'(i), 0, 0, 0, i + 1, 1, 11'h000, 0, 0, (i + 1) >= 12), 100 + i);
    apply(mk(0, 1, 11'h3AA, 0, 0, 0, 16, 1, 11'h000, 1, 1, 1), 120);

    // Full with simultaneous push and pop: accepted, level unchanged.
    apply(mk(0, 1, 11'h155, 1, 0, 0, 16, 1, 11'h001, 1, 1, 1), 130);
    for (int k = 0; k < 16; k++) begin
      logic [10:0] nh;
      nh = (k < 14) ? 11'(k + 2) : (k == 14) ? 11'h155 : 11'h000;
      apply(mk(0, 0, 11'h000, 1, 0, 0, 15 - k, (15 - k) != 0, nh, 1, 1, (15 - k) >= 12), 140 + k);
    end

    // Refill, drop four more to reach drop_count=5, then clear with coincident drop.
    for (int i = 0; i < 16; i++)
      apply(mk(0, 1, 11'(32 + i), 0, 0, 0, i + 1, 1, 11'h020, 1, 1, (i + 1) >= 12), 200 + i);
    for (int i = 0; i < 4; i++)
      apply(mk(0, 1, 11'h3AA, 0, 0, 0, 16, 1, 11'h020, 1, 2 + i, 1), 220 + i);
    apply(mk(0, 1, 11'h3AB, 0, 0, 1, 16, 1, 11'h020, 1, 1, 1), 230);
    apply(mk(0, 0, 11'h000, 0, 0, 1, 16, 1, 11'h020, 0, 0, 1), 231);

    // Flush of a full FIFO with a push: no drop counted.
    apply(mk(0, 1, 11'h3CC, 0, 1, 0, 0, 0, 11'h000, 0, 0, 0), 240);
    for (int i = 0; i < 5; i++)
      apply(mk(0, 1, 11'(48 + i), 0, 0, 0, i + 1, 1, 11'h030, 0, 0, 0), 250 + i);
    apply(mk(0, 1, 11'h222, 0, 1, 0, 0, 0, 11'h000, 0, 0, 0), 260);
    apply(mk(0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0), 261);

    // Refill three, then drop-free overflow setup and mid-operation reset.
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 11'(64 + i), 0, 0, 0, i + 1, 1, 11'h040, 0, 0, 0), 270 + i);
    apply(mk(1, 1, 11'h777, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0), 280);
    apply(mk(0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h000, 0, 0, 0), 281);

`ifdef CAN_FIFO_TIMESTAMP_EN
    begin
      logic [31:0] ts0, ts1;
      apply(mk(0, 1, 11'h100, 0, 0, 0, 1, 1, 11'h100, 0, 0, 0), 300);
      for (int i = 0; i < 7; i++)
        apply(mk(0, 0, 11'h000, 0, 0, 0, 1, 1, 11'h100, 0, 0, 0), 301 + i);
      apply(mk(0, 1, 11'h101, 0, 0, 0, 2, 1, 11'h100, 0, 0, 0), 310);
      ts0 = bus.rd_ts;
      apply(mk(0, 0, 11'h000, 1, 0, 0, 1, 1, 11'h101, 0, 0, 0), 311);
      ts1 = bus.rd_ts;
      chk("ts_delta", 312, ts1 - ts0, 32'd8);
    end
`endif

    rst = 1'b0; bus.id_valid_in = 1'b0; bus.rd_ready = 1'b0; flush = 1'b0; clear_ovf = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
